// File: rtl/alu_ctrl_if.sv
// Command, ALU-drive and result bundle between the alu_ctrl sequencer and its environment.
// slave is the sequencer's view; master is the command source / result sink / alu side.
`timescale 1ns/1ps
interface alu_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_sel;
  logic [7:0] cmd_opA;
  logic [7:0] cmd_opB;
  logic       cmd_useacc;

  logic [7:0] alu_opA;
  logic [7:0] alu_opB;
  logic [2:0] alu_sel;
  logic [7:0] alu_res;

  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_zero;
  logic [7:0] acc;
  logic [7:0] cnt;

  modport slave (
    input  cmd_valid, cmd_sel, cmd_opA, cmd_opB, cmd_useacc, alu_res, res_ready,
    output cmd_ready, alu_opA, alu_opB, alu_sel, res_valid, res_data, res_zero, acc, cnt
  );

  modport master (
    output cmd_valid, cmd_sel, cmd_opA, cmd_opB, cmd_useacc, alu_res, res_ready,
    input  cmd_ready, alu_opA, alu_opB, alu_sel, res_valid, res_data, res_zero, acc, cnt
  );
endinterface

// File: rtl/alu_ctrl.sv
// Sequencer for the 8-bit combinational alu: accept -> EXEC -> DONE, result valid 2 cycles after accept.
// One command in flight; cmd_ready only in IDLE, result held in DONE until res_ready.
`timescale 1ns/1ps
module alu_ctrl (
  input  logic         clk,
  input  logic         rst,
  alu_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic       accept, capture, retire;
  logic       cmd_ready_c, res_valid_c;

  logic [7:0] opa_q, opb_q, res_q, acc_q, cnt_q;
  logic [2:0] sel_q;
  logic       zero_q;

  // Zero detection depends on the number format the captured sel implies.
  function automatic logic zero_rule(input logic [2:0] sel, input logic [7:0] r);
    logic z;
    z = 1'b0;
    case (sel)
      3'b010, 3'b011: z = (r == 8'h00) || (r == 8'hFF);
      3'b100, 3'b101: z = (r == 8'h00) || (r == 8'h80);
      default:        z = (r == 8'h00);
    endcase
    return z;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    capture     = 1'b0;
    retire      = 1'b0;
    cmd_ready_c = 1'b0;
    res_valid_c = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready_c = 1'b1;
        if (bus.cmd_valid) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        capture   = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        res_valid_c = 1'b1;
        if (bus.res_ready) begin
          retire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opa_q  <= 8'h00;
      opb_q  <= 8'h00;
      sel_q  <= 3'b000;
      res_q  <= 8'h00;
      acc_q  <= 8'h00;
      zero_q <= 1'b0;
      cnt_q  <= 8'h00;
    end else begin
      // Operands only move on acceptance, keeping alu inputs steady through EXEC and DONE.
      if (accept) begin
        opa_q <= bus.cmd_useacc ? acc_q : bus.cmd_opA;
        opb_q <= bus.cmd_opB;
        sel_q <= bus.cmd_sel;
      end
      if (capture) begin
        res_q  <= bus.alu_res;
        acc_q  <= bus.alu_res;
        zero_q <= zero_rule(sel_q, bus.alu_res);
      end
      if (retire) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  assign bus.cmd_ready = cmd_ready_c;
  assign bus.res_valid = res_valid_c;
  assign bus.alu_opA   = opa_q;
  assign bus.alu_opB   = opb_q;
  assign bus.alu_sel   = sel_q;
  assign bus.res_data  = res_q;
  assign bus.res_zero  = zero_q;
  assign bus.acc       = acc_q;
  assign bus.cnt       = cnt_q;

  a_ready_valid_excl: assert property (@(posedge clk) disable iff (rst)
    !(cmd_ready_c && res_valid_c));
  a_res_valid_hold: assert property (@(posedge clk) disable iff (rst)
    (res_valid_c && !bus.res_ready) |=> (res_valid_c && $stable(res_q)));
  a_operands_stable: assert property (@(posedge clk) disable iff (rst)
    (state != IDLE) |=> ($stable(opa_q) && $stable(opb_q) && $stable(sel_q)));

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl with a behavioural alu closing the loop on alu_res.
`timescale 1ns/1ps
module tb_alu_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   errs = 0;
  logic [7:0] exp_cnt = 8'h00;

  alu_ctrl_if bus();

  alu_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // alu: 000 add, 001 sub, 010/011 1's-comp add/sub, 100/101 sign-mag add/sub, 110 and, 111 xor
  function automatic logic [7:0] alu_model(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] t;
    logic [6:0] ma, mb;
    logic       sa, sb;
    logic [7:0] r;
    r = 8'h00; t = 9'h000; ma = a[6:0]; mb = b[6:0]; sa = a[7]; sb = b[7];
    case (s)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: begin t = {1'b0, a} + {1'b0, b};  r = t[7:0] + {7'd0, t[8]}; end
      3'd3: begin t = {1'b0, a} + {1'b0, ~b}; r = t[7:0] + {7'd0, t[8]}; end
      3'd4, 3'd5: begin
        if (s == 3'd5) sb = ~sb;
        if (sa == sb)      r = {sa, 7'(ma + mb)};
        else if (ma >= mb) r = {sa, 7'(ma - mb)};
        else               r = {sb, 7'(mb - ma)};
      end
      3'd6: r = a & b;
      default: r = a ^ b;
    endcase
    return r;
  endfunction

  function automatic logic exp_zero(input logic [2:0] s, input logic [7:0] r);
    if (s == 3'd2 || s == 3'd3) return (r == 8'h00) || (r == 8'hFF);
    if (s == 3'd4 || s == 3'd5) return (r == 8'h00) || (r == 8'h80);
    return r == 8'h00;
  endfunction

  assign bus.alu_res = alu_model(bus.alu_sel, bus.alu_opA, bus.alu_opB);

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Presents a command in IDLE; returns one cycle after the accepting edge (EXEC).
  task automatic issue(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b, input logic u);
    bus.cmd_sel = s; bus.cmd_opA = a; bus.cmd_opB = b; bus.cmd_useacc = u; bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    vecs++; if (bus.cmd_ready !== 1'b1) begin errs++; $display("FAIL reset_cmd_ready got %b exp 1", bus.cmd_ready); end
    vecs++; if (bus.res_valid !== 1'b0) begin errs++; $display("FAIL reset_res_valid got %b exp 0", bus.res_valid); end
    vecs++; if (bus.alu_opA !== 8'h00) begin errs++; $display("FAIL reset_alu_opA got %h exp 00", bus.alu_opA); end
    vecs++; if (bus.alu_opB !== 8'h00) begin errs++; $display("FAIL reset_alu_opB got %h exp 00", bus.alu_opB); end
    vecs++; if (bus.alu_sel !== 3'b000) begin errs++; $display("FAIL reset_alu_sel got %b exp 000", bus.alu_sel); end
    vecs++; if (bus.res_data !== 8'h00) begin errs++; $display("FAIL reset_res_data got %h exp 00", bus.res_data); end
    vecs++; if (bus.res_zero !== 1'b0) begin errs++; $display("FAIL reset_res_zero got %b exp 0", bus.res_zero); end
    vecs++; if (bus.acc !== 8'h00) begin errs++; $display("FAIL reset_acc got %h exp 00", bus.acc); end
    vecs++; if (bus.cnt !== 8'h00) begin errs++; $display("FAIL reset_cnt got %h exp 00", bus.cnt); end
    exp_cnt = 8'h00;
  endtask

  task automatic test_add();
    bus.res_ready = 1'b1;
    issue(3'b000, 8'hFD, 8'hFC, 1'b0);
    vecs++; if (bus.cmd_ready !== 1'b0) begin errs++; $display("FAIL add_exec_cmd_ready got %b exp 0", bus.cmd_ready); end
    vecs++; if (bus.res_valid !== 1'b0) begin errs++; $display("FAIL add_exec_res_valid got %b exp 0", bus.res_valid); end
    vecs++; if (bus.alu_opA !== 8'hFD) begin errs++; $display("FAIL add_alu_opA got %h exp FD", bus.alu_opA); end
    vecs++; if (bus.alu_opB !== 8'hFC) begin errs++; $display("FAIL add_alu_opB got %h exp FC", bus.alu_opB); end
    step();
    vecs++; if (bus.res_valid !== 1'b1) begin errs++; $display("FAIL add_res_valid got %b exp 1", bus.res_valid); end
    vecs++; if (bus.res_data !== 8'hF9) begin errs++; $display("FAIL add_res_data got %h exp F9", bus.res_data); end
    vecs++; if (bus.res_zero !== 1'b0) begin errs++; $display("FAIL add_res_zero got %b exp 0", bus.res_zero); end
    vecs++; if (bus.acc !== 8'hF9) begin errs++; $display("FAIL add_acc got %h exp F9", bus.acc); end
    step();
    exp_cnt++;
    vecs++; if (bus.cnt !== exp_cnt) begin errs++; $display("FAIL add_cnt got %h exp %h", bus.cnt, exp_cnt); end
    vecs++; if (bus.cmd_ready !== 1'b1) begin errs++; $display("FAIL add_cmd_ready_back got %b exp 1", bus.cmd_ready); end
    vecs++; if (bus.res_valid !== 1'b0) begin errs++; $display("FAIL add_res_valid_drop got %b exp 0", bus.res_valid); end
  endtask

  task automatic test_chain();
    issue(3'b000, 8'h55, 8'h07, 1'b1);
    vecs++; if (bus.alu_opA !== 8'hF9) begin errs++; $display("FAIL chain_alu_opA got %h exp F9", bus.alu_opA); end
    step();
    vecs++; if (bus.res_data !== 8'h00) begin errs++; $display("FAIL chain_res_data got %h exp 00", bus.res_data); end
    vecs++; if (bus.res_zero !== 1'b1) begin errs++; $display("FAIL chain_res_zero got %b exp 1", bus.res_zero); end
    step();
    exp_cnt++;
    vecs++; if (bus.cnt !== exp_cnt) begin errs++; $display("FAIL chain_cnt got %h exp %h", bus.cnt, exp_cnt); end
  endtask

  logic [2:0] zt_sel [3] = '{3'b011, 3'b100, 3'b110};
  logic [7:0] zt_a   [3] = '{8'h03, 8'h83, 8'h83};
  logic [7:0] zt_b   [3] = '{8'h03, 8'h84, 8'h04};
  logic [7:0] zt_res [3] = '{8'hFF, 8'h87, 8'h00};
  logic       zt_z   [3] = '{1'b1, 1'b0, 1'b1};

  task automatic test_zero_format();
    for (int i = 0; i < 3; i++) begin
      issue(zt_sel[i], zt_a[i], zt_b[i], 1'b0);
      step();
      vecs++; if (bus.res_data !== zt_res[i]) begin errs++; $display("FAIL zero_fmt%0d_data got %h exp %h", i, bus.res_data, zt_res[i]); end
      vecs++; if (bus.res_zero !== zt_z[i]) begin errs++; $display("FAIL zero_fmt%0d_zero got %b exp %b", i, bus.res_zero, zt_z[i]); end
      step();
      exp_cnt++;
    end
    vecs++; if (bus.cnt !== exp_cnt) begin errs++; $display("FAIL zero_fmt_cnt got %h exp %h", bus.cnt, exp_cnt); end
  endtask

  task automatic test_backpressure();
    bus.res_ready = 1'b0;
    issue(3'b010, 8'hFC, 8'hFB, 1'b0);
    bus.cmd_sel = 3'b000; bus.cmd_opA = 8'h11; bus.cmd_opB = 8'h22; bus.cmd_useacc = 1'b0;
    bus.cmd_valid = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      vecs++; if (bus.res_valid !== 1'b1) begin errs++; $display("FAIL bp%0d_res_valid got %b exp 1", i, bus.res_valid); end
      vecs++; if (bus.res_data !== 8'hF8) begin errs++; $display("FAIL bp%0d_res_data got %h exp F8", i, bus.res_data); end
      vecs++; if (bus.cmd_ready !== 1'b0) begin errs++; $display("FAIL bp%0d_cmd_ready got %b exp 0", i, bus.cmd_ready); end
      vecs++; if (bus.alu_opA !== 8'hFC || bus.alu_opB !== 8'hFB) begin errs++; $display("FAIL bp%0d_operands got %h/%h exp FC/FB", i, bus.alu_opA, bus.alu_opB); end
      vecs++; if (bus.cnt !== exp_cnt) begin errs++; $display("FAIL bp%0d_cnt got %h exp %h", i, bus.cnt, exp_cnt); end
      step();
    end
    bus.res_ready = 1'b1;
    step();
    exp_cnt++;
    vecs++; if (bus.cnt !== exp_cnt) begin errs++; $display("FAIL bp_release_cnt got %h exp %h", bus.cnt, exp_cnt); end
    vecs++; if (bus.cmd_ready !== 1'b1) begin errs++; $display("FAIL bp_release_cmd_ready got %b exp 1", bus.cmd_ready); end
    step();
    bus.cmd_valid = 1'b0;
    vecs++; if (bus.alu_opA !== 8'h11 || bus.alu_opB !== 8'h22) begin errs++; $display("FAIL bp_second_operands got %h/%h exp 11/22", bus.alu_opA, bus.alu_opB); end
    step();
    vecs++; if (bus.res_data !== 8'h33) begin errs++; $display("FAIL bp_second_data got %h exp 33", bus.res_data); end
    step();
    exp_cnt++;
    vecs++; if (bus.cnt !== exp_cnt) begin errs++; $display("FAIL bp_second_cnt got %h exp %h", bus.cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; step(); rst = 1'b0;
    exp_cnt = 8'h00;
    bus.res_ready = 1'b1;
    issue(3'b000, 8'h01, 8'h02, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    vecs++; if (bus.res_valid !== 1'b0) begin errs++; $display("FAIL rstmid_res_valid got %b exp 0", bus.res_valid); end
    vecs++; if (bus.cmd_ready !== 1'b1) begin errs++; $display("FAIL rstmid_cmd_ready got %b exp 1", bus.cmd_ready); end
    vecs++; if (bus.acc !== 8'h00) begin errs++; $display("FAIL rstmid_acc got %h exp 00", bus.acc); end
    vecs++; if (bus.cnt !== 8'h00) begin errs++; $display("FAIL rstmid_cnt got %h exp 00", bus.cnt); end
    vecs++; if (bus.res_data !== 8'h00) begin errs++; $display("FAIL rstmid_res_data got %h exp 00", bus.res_data); end
    for (int i = 0; i < 3; i++) begin
      step();
      vecs++; if (bus.res_valid !== 1'b0) begin errs++; $display("FAIL rstmid_late%0d_res_valid got %b exp 0", i, bus.res_valid); end
    end
  endtask

  task automatic test_back_to_back_wrap();
    logic [2:0] s;
    logic [7:0] a, b, opa, r, acc_m;
    logic       u;
    acc_m = 8'h00;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      s = 3'($urandom_range(0, 7));
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      u = 1'($urandom_range(0, 1));
      opa = u ? acc_m : a;
      r = alu_model(s, opa, b);
      issue(s, a, b, u);
      vecs++; if (bus.alu_opA !== opa) begin errs++; $display("FAIL wrap%0d_alu_opA got %h exp %h", i, bus.alu_opA, opa); end
      step();
      vecs++; if (bus.res_data !== r) begin errs++; $display("FAIL wrap%0d_res_data got %h exp %h", i, bus.res_data, r); end
      vecs++; if (bus.res_zero !== exp_zero(s, r)) begin errs++; $display("FAIL wrap%0d_res_zero got %b exp %b", i, bus.res_zero, exp_zero(s, r)); end
      acc_m = r;
      step();
      exp_cnt++;
      vecs++; if (bus.cnt !== exp_cnt) begin errs++; $display("FAIL wrap%0d_cnt got %h exp %h", i, bus.cnt, exp_cnt); end
      if (i == 254) begin
        vecs++; if (bus.cnt !== 8'hFF) begin errs++; $display("FAIL wrap_cnt_255 got %h exp FF", bus.cnt); end
      end
    end
    vecs++; if (bus.cnt !== 8'h00) begin errs++; $display("FAIL wrap_cnt_256 got %h exp 00", bus.cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_sel = 3'b000; bus.cmd_opA = 8'h00; bus.cmd_opB = 8'h00;
    bus.cmd_useacc = 1'b0; bus.res_ready = 1'b0;
    test_reset();
    test_add();
    test_chain();
    test_zero_format();
    test_backpressure();
    test_reset_mid();
    test_back_to_back_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Sequencing front-end for the 8-bit combinational `alu` (8-bit operands, 3-bit `sel`, 8-bit result).
- Accepts one command at a time over a valid/ready handshake.
- Holds the ALU operands and `sel` stable in registers for a full evaluation cycle.
- Captures the ALU result into an accumulator and an output register, and presents it downstream with a valid/ready handshake.
- Sits directly upstream of `alu`, driving its `opA`/`opB`/`sel`, and also consumes its `res`.

## Interface
Parameters:
- none (datapath fixed at 8 bits, `sel` fixed at 3 bits to match `alu`)

Ports:
- `clk`  in  1  single clock; every register updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command; equals (state == IDLE).
- `cmd_sel`  in  3  ALU operation code, passed unchanged to `alu`.
- `cmd_opA`  in  8  operand A.
- `cmd_opB`  in  8  operand B.
- `cmd_useacc`  in  1  1: use the accumulator as operand A and ignore `cmd_opA`.
- `alu_opA`  out  8  registered operand A to `alu`.
- `alu_opB`  out  8  registered operand B to `alu`.
- `alu_sel`  out  3  registered `sel` to `alu`.
- `alu_res`  in  8  combinational result from `alu`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  downstream accepts the result.
- `res_data`  out  8  captured result.
- `res_zero`  out  1  captured result is zero in the number format selected by `sel`.
- `acc`  out  8  accumulator (last captured result).
- `cnt`  out  8  count of completed results (handshakes), wraps modulo 256.

## Operation
- **FSM states:** IDLE, EXEC, DONE.
- **IDLE:**
  - `cmd_ready` = 1.
  - On `cmd_valid`:
    - `alu_opA` ← `cmd_useacc ? acc : cmd_opA`.
    - `alu_opB` ← `cmd_opB`.
    - `alu_sel` ← `cmd_sel`.
    - Go to EXEC.
  - Otherwise remain in IDLE.
- **EXEC** (exactly one cycle; `alu` settles within it):
  - `res_data` ← `alu_res`.
  - `acc` ← `alu_res`.
  - `res_zero` ← zero rule below.
  - Go to DONE.
- **DONE:**
  - `res_valid` = 1.
  - On `res_ready`: `cnt` ← `cnt` + 1 (8-bit wrap), go to IDLE.
  - Otherwise hold all registers.
- **Zero rule** (evaluated against the captured `sel`):
  - `sel` 000, 001, 110, 111: zero iff result == 8'h00.
  - `sel` 010, 011 (1's complement): zero iff result is 8'h00 or 8'hFF.
  - `sel` 100, 101 (sign-magnitude): zero iff result is 8'h00 or 8'h80.
- **Stability:** operand registers change only on IDLE acceptance, so `alu` inputs are constant throughout EXEC and DONE.
- **Command inputs outside IDLE:** ignored; `cmd_ready` = 0 in EXEC and DONE.
- **Accumulator use:** `acc` is read only at IDLE acceptance when `cmd_useacc` = 1. This allows chained operations such as running sums.
- **Reset (any state, including mid-EXEC/DONE):**
  - State → IDLE.
  - `alu_opA`, `alu_opB`, `res_data`, `acc`, `cnt` → 8'h00.
  - `alu_sel` → 3'b000.
  - `res_zero` → 0.
  - Any in-flight result is discarded and `cnt` does not increment.
  - A command presented while `rst` is high is not accepted.

## Timing
- Edge E0 (`cmd_valid` & `cmd_ready`): operands registered, state → EXEC.
- Edge E1: result captured, state → DONE; `res_valid` = 1 from after E1.
- Minimum latency from command accept to `res_valid`: 2 cycles.
- Minimum initiation interval: 3 cycles (IDLE, EXEC, DONE), when `res_ready` is held at 1.
- `res_data`, `res_zero`, `acc` are stable from E1 until the next EXEC capture.
- Result handshake is valid-before-ready: `res_valid` never depends combinationally on `res_ready`, and never drops without a handshake except on `rst`.
- `cmd_ready` and `res_valid` are mutually exclusive.
- **Reset values after the reset edge:**
  - `cmd_ready` = 1, `res_valid` = 0.
  - All data outputs = 0.

## Test plan
- **Two's-complement add:** reset, then `cmd_sel`=000, opA=8'hFD, opB=8'hFC, `cmd_useacc`=0, `res_ready`=1 → `res_valid` high 2 cycles after accept; `res_data`=8'hF9, `res_zero`=0, `acc`=8'hF9, `cnt`=1; `cmd_ready` back to 1 on the next cycle.
- **Accumulator chain:** after the previous scenario, `cmd_useacc`=1, `cmd_sel`=000, opB=8'h07, `cmd_opA`=8'h55 → `alu_opA`=8'hF9 during EXEC (not 8'h55); `res_data`=8'h00, `res_zero`=1, `cnt`=2.
- **Format-dependent zero:**
  - `sel`=011, opA=8'h03, opB=8'h03 → `res_data`=8'hFF, `res_zero`=1.
  - `sel`=100, opA=8'h83, opB=8'h84 → `res_data`=8'h87, `res_zero`=0.
  - `sel`=110, opA=8'h83, opB=8'h04 → `res_data`=8'h00, `res_zero`=1.
- **Backpressure:** `sel`=010, opA=8'hFC, opB=8'hFB, `res_ready`=0 for 6 cycles while a second `cmd_valid` is held high → `res_valid`=1 and `res_data`=8'hF8 held constant; `cmd_ready`=0 and `alu_opA`/`alu_opB` unchanged throughout; after `res_ready`=1, one handshake occurs, `cnt` increments once, and the second command is then accepted.
- **Reset mid-operation:** accept a command, assert `rst` in the EXEC cycle → next cycle `res_valid`=0, `cmd_ready`=1, `acc`=8'h00, `cnt` unchanged from its reset value 8'h00; no result is ever presented for that command.
- **Counter wrap:** 256 back-to-back commands with `res_ready`=1 → `cnt` reads 8'hFF after 255 handshakes and 8'h00 after 256; every result checked against a reference model of `alu`.
